// File: rtl/axil_reg_master_pkg.sv
// Shared constants and types for the AXI4-Lite to register-bus bridge.
package axil_reg_master_pkg;

   localparam int unsigned RegAddrW = 16;
   localparam int unsigned RegDataW = 64;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWrIssue,
      StWrResp,
      StRdIssue,
      StRdWait,
      StRdResp
   } state_e;

endpackage

// File: rtl/axil_reg_master.sv
// AXI4-Lite slave port driving a register bus: one-cycle write strobe, fixed-latency reads,
// one access outstanding, round-robin between a full write pair and a pending read.
module axil_reg_master
   import axil_reg_master_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [RegAddrW-1:0]   s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,

   input  logic [RegDataW-1:0]   s_axil_wdata,
   input  logic [RegDataW/8-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,

   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,

   input  logic [RegAddrW-1:0]   s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,

   output logic [RegDataW-1:0]   s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,

   output logic                  o_reg_wen,
   output logic [RegAddrW-1:0]   o_reg_waddr,
   output logic [RegDataW-1:0]   o_reg_wdata,
   output logic                  o_reg_ren,
   output logic [RegAddrW-1:0]   o_reg_raddr,
   input  logic [RegDataW-1:0]   i_reg_rdata
);

   state_e                  state;
   logic                    aw_full, w_full;
   logic [RegAddrW-1:0]     aw_addr;
   logic [RegDataW-1:0]     w_data;
   logic [RegDataW/8-1:0]   w_strb;
   logic                    last_rd;
   logic                    wr_ok;
   logic [3:0]              cnt;

   logic wr_pair, grant_wr, wr_legal, rd_legal;

   assign wr_pair  = aw_full & w_full;
   assign wr_legal = (aw_addr[2:0] == 3'b000) && (w_strb == '1);
   assign rd_legal = (s_axil_araddr[2:0] == 3'b000);

   // On contention the side that did not win last time goes first.
   assign grant_wr       = (state == StIdle) & wr_pair & (~s_axil_arvalid | last_rd);
   assign s_axil_arready = ~rst & (state == StIdle) & s_axil_arvalid & ~(wr_pair & last_rd);
   assign s_axil_awready = ~rst & ~aw_full;
   assign s_axil_wready  = ~rst & ~w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         last_rd       <= 1'b1;
         wr_ok         <= 1'b0;
         cnt           <= '0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= '0;
         s_axil_rvalid <= 1'b0;
         s_axil_rresp  <= '0;
         s_axil_rdata  <= '0;
         o_reg_wen     <= 1'b0;
         o_reg_waddr   <= '0;
         o_reg_wdata   <= '0;
         o_reg_ren     <= 1'b0;
         o_reg_raddr   <= '0;
      end else begin
         if (s_axil_awvalid && s_axil_awready) begin
            aw_full <= 1'b1;
            aw_addr <= s_axil_awaddr;
         end
         if (s_axil_wvalid && s_axil_wready) begin
            w_full <= 1'b1;
            w_data <= s_axil_wdata;
            w_strb <= s_axil_wstrb;
         end

         case (state)
            StIdle: begin
               if (grant_wr) begin
                  state     <= StWrIssue;
                  last_rd   <= 1'b0;
                  wr_ok     <= wr_legal;
                  o_reg_wen <= wr_legal;
                  if (wr_legal) begin
                     o_reg_waddr <= aw_addr;
                     o_reg_wdata <= w_data;
                  end
               end else if (s_axil_arready) begin
                  state     <= StRdIssue;
                  last_rd   <= 1'b1;
                  o_reg_ren <= rd_legal;
                  if (rd_legal) o_reg_raddr <= s_axil_araddr;
               end
            end
            StWrIssue: begin
               o_reg_wen     <= 1'b0;
               aw_full       <= 1'b0;
               w_full        <= 1'b0;
               s_axil_bvalid <= 1'b1;
               s_axil_bresp  <= wr_ok ? RespOkay : RespSlverr;
               state         <= StWrResp;
            end
            StWrResp: begin
               if (s_axil_bready) begin
                  s_axil_bvalid <= 1'b0;
                  state         <= StIdle;
               end
            end
            StRdIssue: begin
               // A set read strobe doubles as the legality flag for this access.
               o_reg_ren <= 1'b0;
               if (o_reg_ren) begin
                  cnt   <= 4'd1;
                  state <= StRdWait;
               end else begin
                  s_axil_rvalid <= 1'b1;
                  s_axil_rdata  <= '0;
                  s_axil_rresp  <= RespSlverr;
                  state         <= StRdResp;
               end
            end
            StRdWait: begin
               if (cnt == 4'(RD_LATENCY)) begin
                  cnt           <= '0;
                  s_axil_rvalid <= 1'b1;
                  s_axil_rdata  <= i_reg_rdata;
                  s_axil_rresp  <= RespOkay;
                  state         <= StRdResp;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            StRdResp: begin
               if (s_axil_rready) begin
                  s_axil_rvalid <= 1'b0;
                  state         <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_reg_master.sv
// Self-checking bench for axil_reg_master: scoreboard of expected bus/response events,
// a vector table for single accesses and directed sequences for timing corners.
module tb_axil_reg_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_axil_awaddr = '0;
   logic        s_axil_awvalid = 1'b0;
   logic        s_axil_awready;
   logic [63:0] s_axil_wdata = '0;
   logic [7:0]  s_axil_wstrb = '0;
   logic        s_axil_wvalid = 1'b0;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready = 1'b1;
   logic [15:0] s_axil_araddr = '0;
   logic        s_axil_arvalid = 1'b0;
   logic        s_axil_arready;
   logic [63:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready = 1'b1;
   logic        o_reg_wen;
   logic [15:0] o_reg_waddr;
   logic [63:0] o_reg_wdata;
   logic        o_reg_ren;
   logic [15:0] o_reg_raddr;
   logic [63:0] i_reg_rdata = '0;

   axil_reg_master #(.RD_LATENCY(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .o_reg_wen      (o_reg_wen),
      .o_reg_waddr    (o_reg_waddr),
      .o_reg_wdata    (o_reg_wdata),
      .o_reg_ren      (o_reg_ren),
      .o_reg_raddr    (o_reg_raddr),
      .i_reg_rdata    (i_reg_rdata)
   );

   always #5 clk = ~clk;

   typedef enum logic [3:0] {EvWen, EvRen, EvB, EvR} ev_e;
   typedef struct {
      ev_e         kind;
      logic [15:0] addr;
      logic [63:0] data;
      logic [1:0]  resp;
   } ev_t;

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [1:0]  exp_resp;
   } vec_t;

   ev_t  exp_q[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [63:0] rd_fn(input logic [15:0] a);
      if (a == 16'h0100) return 64'h1000_0000_0000_5AA5;
      return {a, 16'hC0DE, ~a, a ^ 16'h3C3C};
   endfunction

   function automatic logic [191:0] outs();
      return 192'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                   s_axil_bresp, s_axil_rresp, s_axil_rdata, o_reg_wen, o_reg_ren,
                   o_reg_waddr, o_reg_wdata, o_reg_raddr});
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input ev_e k, input logic [15:0] a, input logic [63:0] d,
                       input logic [1:0] r);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.resp = r;
      exp_q.push_back(e);
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [63:0] d, input logic [1:0] r);
      if (r == 2'b00) push(EvWen, a, d, 2'b00);
      push(EvB, 16'h0, 64'h0, r);
   endtask

   task automatic expect_rd(input logic [15:0] a, input logic [1:0] r);
      if (r == 2'b00) push(EvRen, a, 64'h0, 2'b00);
      push(EvR, 16'h0, (r == 2'b00) ? rd_fn(a) : 64'h0, r);
   endtask

   task automatic got(input ev_e k, input logic [15:0] a, input logic [63:0] d,
                      input logic [1:0] r);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got event, expected none", k.name());
         return;
      end
      e = exp_q.pop_front();
      chk({"event_", e.kind.name()}, 192'({k, a, d, r}), 192'({e.kind, e.addr, e.data, e.resp}));
   endtask

   // Register-bus responder and event monitor, sampled mid low phase.
   logic        rd_pend = 1'b0;
   logic [15:0] rd_a = '0;
   always @(negedge clk) begin
      #2;
      i_reg_rdata = rd_pend ? rd_fn(rd_a) : 64'hBAD0_BAD0_BAD0_BAD0;
      rd_pend = 1'b0;
      if (!rst) begin
         if (o_reg_wen || o_reg_ren)
            chk("wen_ren_exclusive", 192'(o_reg_wen & o_reg_ren), 192'(0));
         if (o_reg_wen) got(EvWen, o_reg_waddr, o_reg_wdata, 2'b00);
         if (o_reg_ren) begin
            got(EvRen, o_reg_raddr, 64'h0, 2'b00);
            rd_pend = 1'b1;
            rd_a    = o_reg_raddr;
         end
         if (s_axil_bvalid && s_axil_bready) got(EvB, 16'h0, 64'h0, s_axil_bresp);
         if (s_axil_rvalid && s_axil_rready) got(EvR, 16'h0, s_axil_rdata, s_axil_rresp);
      end
   end

   task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
      int  n = 0;
      logic aw_hs, w_hs;
      s_axil_awaddr  = a;
      s_axil_wdata   = d;
      s_axil_wstrb   = s;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      while ((s_axil_awvalid || s_axil_wvalid) && n < 100) begin
         #1;
         aw_hs = s_axil_awvalid & s_axil_awready;
         w_hs  = s_axil_wvalid & s_axil_wready;
         @(negedge clk);
         if (aw_hs) s_axil_awvalid = 1'b0;
         if (w_hs) s_axil_wvalid = 1'b0;
         n++;
      end
      if (s_axil_awvalid || s_axil_wvalid) begin
         checks++;
         errors++;
         $display("FAIL write_accept_timeout: addr %0h not accepted within %0d cycles", a, n);
         s_axil_awvalid = 1'b0;
         s_axil_wvalid  = 1'b0;
      end
   endtask

   task automatic do_read(input logic [15:0] a);
      int  n = 0;
      logic ar_hs;
      s_axil_araddr  = a;
      s_axil_arvalid = 1'b1;
      while (s_axil_arvalid && n < 100) begin
         #1;
         ar_hs = s_axil_arready;
         @(negedge clk);
         if (ar_hs) s_axil_arvalid = 1'b0;
         n++;
      end
      if (s_axil_arvalid) begin
         checks++;
         errors++;
         $display("FAIL read_accept_timeout: addr %0h not accepted within %0d cycles", a, n);
         s_axil_arvalid = 1'b0;
      end
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain"}, 192'(exp_q.size()), 192'(0));
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int rv_seen;

      vecs[0] = '{1'b1, 16'h0108, 64'h0000_0000_8000_0000, 8'hFF, 2'b00};
      vecs[1] = '{1'b1, 16'h0104, 64'h1111_2222_3333_4444, 8'hFF, 2'b10};
      vecs[2] = '{1'b1, 16'h0108, 64'h5555_6666_7777_8888, 8'h0F, 2'b10};
      vecs[3] = '{1'b0, 16'h0003, 64'h0,                   8'h00, 2'b10};
      vecs[4] = '{1'b0, 16'h0100, 64'h0,                   8'h00, 2'b00};
      vecs[5] = '{1'b1, 16'hFFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00};
      vecs[6] = '{1'b0, 16'hFFF8, 64'h0,                   8'h00, 2'b00};
      vecs[7] = '{1'b1, 16'h0000, 64'h0123_4567_89AB_CDEF, 8'hFE, 2'b10};
      vecs[8] = '{1'b0, 16'h0001, 64'h0,                   8'h00, 2'b10};

      // Reset state, readies back right after release.
      s_axil_arvalid = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 192'(0));
      s_axil_arvalid = 1'b0;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 192'({s_axil_awready, s_axil_wready}), 192'(2'b11));
      @(negedge clk);

      // Legal write latency: accept -> wen 2 cycles, wen -> bvalid 1 cycle.
      expect_wr(16'h0108, 64'h0000_0000_8000_0000, 2'b00);
      s_axil_awaddr  = 16'h0108;
      s_axil_wdata   = 64'h0000_0000_8000_0000;
      s_axil_wstrb   = 8'hFF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      @(negedge clk);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      lat = 1;
      while (!o_reg_wen && lat < 20) begin @(negedge clk); lat++; end
      chk("lat_accept_to_wen", 192'(lat), 192'(2));
      lat = 0;
      while (!s_axil_bvalid && lat < 20) begin @(negedge clk); lat++; end
      chk("lat_wen_to_bvalid", 192'(lat), 192'(1));
      wait_drain("wr_lat");

      // Legal read latency: accept -> ren 1 cycle, ren -> rvalid 2 cycles.
      expect_rd(16'h0100, 2'b00);
      s_axil_araddr  = 16'h0100;
      s_axil_arvalid = 1'b1;
      #1;
      chk("arready_idle", 192'(s_axil_arready), 192'(1));
      @(negedge clk);
      s_axil_arvalid = 1'b0;
      lat = 1;
      while (!o_reg_ren && lat < 20) begin @(negedge clk); lat++; end
      chk("lat_accept_to_ren", 192'(lat), 192'(1));
      lat = 0;
      while (!s_axil_rvalid && lat < 20) begin @(negedge clk); lat++; end
      chk("lat_ren_to_rvalid", 192'(lat), 192'(2));
      wait_drain("rd_lat");

      // Arbitration: continuous contention, last grant was a read -> W, R, W.
      expect_wr(16'h0008, 64'hAAAA_0000_0000_0001, 2'b00);
      expect_rd(16'h0010, 2'b00);
      expect_wr(16'h0018, 64'hBBBB_0000_0000_0002, 2'b00);
      expect_rd(16'h0020, 2'b00);
      fork
         begin
            do_write(16'h0008, 64'hAAAA_0000_0000_0001, 8'hFF);
            do_write(16'h0018, 64'hBBBB_0000_0000_0002, 8'hFF);
         end
         begin
            @(negedge clk);
            do_read(16'h0010);
            do_read(16'h0020);
         end
      join
      wait_drain("arb");

      // Single-access vector table.
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].is_wr) begin
            expect_wr(vecs[i].addr, vecs[i].data, vecs[i].exp_resp);
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         end else begin
            expect_rd(vecs[i].addr, vecs[i].exp_resp);
            do_read(vecs[i].addr);
         end
         wait_drain($sformatf("vec%0d", i));
      end

      // Backpressure: response held, pending read not issued meanwhile.
      s_axil_bready = 1'b0;
      s_axil_rready = 1'b0;
      expect_wr(16'h0040, 64'hCAFE_F00D_1234_5678, 2'b00);
      expect_rd(16'h0200, 2'b00);
      do_write(16'h0040, 64'hCAFE_F00D_1234_5678, 8'hFF);
      fork
         do_read(16'h0200);
      join_none
      lat = 0;
      while (!s_axil_bvalid && lat < 20) begin @(negedge clk); lat++; end
      for (int i = 0; i < 10; i++) begin
         chk("bp_b_hold", 192'({s_axil_bvalid, s_axil_bresp, o_reg_wen, o_reg_ren}),
             192'({1'b1, 2'b00, 1'b0, 1'b0}));
         @(negedge clk);
      end
      s_axil_bready = 1'b1;
      lat = 0;
      while (!s_axil_rvalid && lat < 30) begin @(negedge clk); lat++; end
      for (int i = 0; i < 5; i++) begin
         chk("bp_r_hold", 192'({s_axil_rvalid, s_axil_rresp, s_axil_rdata, o_reg_wen, o_reg_ren}),
             192'({1'b1, 2'b00, rd_fn(16'h0200), 1'b0, 1'b0}));
         @(negedge clk);
      end
      s_axil_rready = 1'b1;
      wait_drain("bp");

      // Reset during RD_WAIT aborts the read; a following write still works.
      expect_rd(16'h0300, 2'b00);
      do_read(16'h0300);
      chk("abort_ren_issued", 192'(o_reg_ren), 192'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_outputs_zero", outs(), 192'(0));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      rv_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (s_axil_rvalid || o_reg_ren) rv_seen++;
      end
      chk("abort_no_response", 192'(rv_seen), 192'(0));
      expect_wr(16'h0400, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00);
      do_write(16'h0400, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF);
      wait_drain("post_reset_wr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
